// File: rtl/scan_sel_if.sv
// Scan select bus between the request source and the scan select generator.
//   en    : scan enable
//   req   : per-channel service request, bit i requests channel i
//   s0/s1 : registered decoder select pair, channel = {s0,s1}
//   valid : {s0,s1} is a live selection
//   wrap  : one-cycle pulse when a grant index is <= the previous pointer
//   busy  : controller is holding a channel
interface scan_sel_if;
  logic       en;
  logic [3:0] req;
  logic       s0;
  logic       s1;
  logic       valid;
  logic       wrap;
  logic       busy;

  modport master (
    output en, req,
    input  s0, s1, valid, wrap, busy
  );

  modport slave (
    input  en, req,
    output s0, s1, valid, wrap, busy
  );
endinterface

// File: rtl/scan_sel_gen.sv
// Round-robin scan controller producing the registered 2-bit select pair for
// an active-low 2-to-4 decoder. Requesting channels are granted in rotation
// and held for DWELL cycles; idle channels are skipped.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : scan_sel_if.slave (en/req in; s0/s1/valid/wrap/busy out)
module scan_sel_gen #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  scan_sel_if.slave  bus
);

  // A dwell of zero behaves as a single-cycle dwell.
  localparam int unsigned DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_EFF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          busy_q, busy_d;

  logic [1:0]    nxt_c;
  logic          any_req_c;
  logic          grant_c;

  // Next requester searching ptr+1, ptr+2, ptr+3, ptr; the last hit written
  // is the closest one after ptr, and ptr itself is checked last.
  always_comb begin
    nxt_c     = ptr_q;
    any_req_c = |bus.req;
    for (int o = 4; o >= 1; o--) begin
      if (bus.req[ptr_q + 2'(o)]) begin
        nxt_c = ptr_q + 2'(o);
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    grant_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.en && any_req_c) begin
          grant_c = 1'b1;
        end
      end
      HOLD: begin
        // Losing en beats an expiring dwell: no grant, no wrap.
        if (!bus.en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (any_req_c) begin
          grant_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_c) begin
      state_d = HOLD;
      ptr_d   = nxt_c;
      sel_d   = nxt_c;
      cnt_d   = CNT_LOAD;
      wrap_d  = (nxt_c <= ptr_q);
    end

    valid_d = (state_d == HOLD);
    busy_d  = (state_d == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.s0    = sel_q[1];
  assign bus.s1    = sel_q[0];
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: five instances (DWELL = 1,2,3,4,0)
// share one stimulus stream and are each compared every cycle against a
// rotation model, with directed checks for the documented scenarios.
module tb_scan_sel_gen;

  localparam int NI = 5;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;

  logic [1:0]    o_sel [NI];
  logic [NI-1:0] o_valid;
  logic [NI-1:0] o_wrap;
  logic [NI-1:0] o_busy;

  int n_cmp;
  int n_bad;

  // Model state per instance.
  int dw_eff [NI] = '{1, 2, 3, 4, 1};
  bit m_act  [NI];
  int m_ptr  [NI];
  int m_left [NI];
  int m_sel  [NI];
  bit m_wrap [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DW = (g == 4) ? 0 : g + 1;
    scan_sel_if bus ();
    assign bus.en  = en;
    assign bus.req = req;
    scan_sel_gen #(.DWELL(DW), .CW(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign o_sel[g]   = {bus.s0, bus.s1};
    assign o_valid[g] = bus.valid;
    assign o_wrap[g]  = bus.wrap;
    assign o_busy[g]  = bus.busy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rotation rules applied to one clock edge for every instance.
  task automatic model_edge(input logic e, input logic [3:0] r, input logic rn);
    for (int k = 0; k < NI; k++) begin
      if (!rn) begin
        m_act[k] = 0; m_ptr[k] = 3; m_left[k] = 0; m_sel[k] = 0; m_wrap[k] = 0;
      end else begin
        m_wrap[k] = 0;
        if (!e) begin
          m_act[k] = 0;
        end else if (m_act[k] && m_left[k] > 0) begin
          m_left[k]--;
        end else if (r != 4'd0) begin
          int g;
          g = m_ptr[k];
          for (int o = 4; o >= 1; o--) begin
            if (r[(m_ptr[k] + o) % 4]) g = (m_ptr[k] + o) % 4;
          end
          m_wrap[k] = (g <= m_ptr[k]);
          m_ptr[k]  = g;
          m_sel[k]  = g;
          m_left[k] = dw_eff[k] - 1;
          m_act[k]  = 1;
        end else begin
          m_act[k] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic rn);
    en = e; req = r; rst_n = rn;
    @(posedge clk);
    model_edge(e, r, rn);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d_sel", k),   32'(o_sel[k]),   32'(m_sel[k]));
      chk($sformatf("i%0d_valid", k), 32'(o_valid[k]), 32'(m_act[k]));
      chk($sformatf("i%0d_busy", k),  32'(o_busy[k]),  32'(m_act[k]));
      chk($sformatf("i%0d_wrap", k),  32'(o_wrap[k]),  32'(m_wrap[k]));
    end
  endtask

  initial begin
    int exp12 [6];
    n_cmp = 0;
    n_bad = 0;
    en = 1'b0; req = 4'd0; rst_n = 1'b0;

    // Reset, then release with en low.
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      step(1'b0, 4'hF, 1'b1);
      chk("rst_sel", 32'(o_sel[3]), 32'd0);
      chk("rst_valid", 32'(o_valid[3]), 32'd0);
      chk("rst_wrap", 32'(o_wrap[3]), 32'd0);
    end

    // DWELL=4, all requesting: 0,1,2,3,0 each four cycles.
    for (int t = 0; t < 20; t++) begin
      step(1'b1, 4'hF, 1'b1);
      chk("d4_sel", 32'(o_sel[3]), 32'((t / 4) % 4));
      chk("d4_valid", 32'(o_valid[3]), 32'd1);
      chk("d4_wrap", 32'(o_wrap[3]), 32'(t % 16 == 0));
    end

    // DWELL=2, req=1010: 1,1,3,3,1,1 with wrap on each return to 1.
    step(1'b0, 4'd0, 1'b0);
    exp12 = '{1, 1, 3, 3, 1, 1};
    for (int t = 0; t < 6; t++) begin
      step(1'b1, 4'b1010, 1'b1);
      chk("d2_sel", 32'(o_sel[1]), 32'(exp12[t]));
      chk("d2_wrap", 32'(o_wrap[1]), 32'(t == 0 || t == 4));
    end

    // DWELL=3, lone requester 2 re-granted every 3 cycles, then req cleared.
    step(1'b0, 4'd0, 1'b0);
    for (int t = 0; t < 9; t++) begin
      step(1'b1, 4'b0100, 1'b1);
      chk("d3_sel", 32'(o_sel[2]), 32'd2);
      chk("d3_wrap", 32'(o_wrap[2]), 32'(t % 3 == 0));
    end
    step(1'b1, 4'd0, 1'b1);
    chk("d3_idle_valid", 32'(o_valid[2]), 32'd0);
    chk("d3_idle_sel", 32'(o_sel[2]), 32'd2);

    // DWELL=4, en drops on the 2nd cycle of channel 1's dwell.
    step(1'b0, 4'd0, 1'b0);
    for (int t = 0; t < 6; t++) step(1'b1, 4'hF, 1'b1);
    chk("drop_pre_sel", 32'(o_sel[3]), 32'd1);
    step(1'b0, 4'hF, 1'b1);
    chk("drop_valid", 32'(o_valid[3]), 32'd0);
    chk("drop_sel", 32'(o_sel[3]), 32'd1);
    step(1'b1, 4'hF, 1'b1);
    chk("resume_sel", 32'(o_sel[3]), 32'd2);
    chk("resume_wrap", 32'(o_wrap[3]), 32'd0);

    // Reset mid-HOLD on channel 3.
    step(1'b0, 4'd0, 1'b0);
    for (int t = 0; t < 13; t++) step(1'b1, 4'hF, 1'b1);
    chk("mid_pre_sel", 32'(o_sel[3]), 32'd3);
    step(1'b1, 4'hF, 1'b0);
    chk("mid_rst_sel", 32'(o_sel[3]), 32'd0);
    chk("mid_rst_valid", 32'(o_valid[3]), 32'd0);
    chk("mid_rst_busy", 32'(o_busy[3]), 32'd0);
    step(1'b1, 4'hF, 1'b1);
    chk("mid_first_sel", 32'(o_sel[3]), 32'd0);
    chk("mid_first_wrap", 32'(o_wrap[3]), 32'd1);

    // Random traffic against the model.
    for (int t = 0; t < 600; t++) begin
      logic       e;
      logic       rn;
      logic [3:0] r;
      rn = ($urandom_range(0, 59) != 0);
      e  = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      step(e, r, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
